// File: rtl/core_queue_bank.sv
// Per-core packet FIFO bank: NB_QUEUES circular queues fed by coreId, popped by popId; drop counter under CORE_QUEUE_BANK_DROP_CNT_EN.
// Latency: a push is visible at the queue head/status one edge later; status is decoded from registered counts only.
// Backpressure: none upstream; pushes to a full queue (without a same-cycle pop) are discarded.
module core_queue_bank #(
    parameter int PACKET_WIDTH = 294,
    parameter int NB_QUEUES    = 4,
    parameter int QUEUE_DEPTH  = 8
) (
    input  logic                                          S_AXI_ACLK,
    input  logic                                          S_AXI_ARESETN,
    input  logic [PACKET_WIDTH-1:0]                       packetIn,
    input  logic                                          packetValid,
    input  logic [$clog2(NB_QUEUES)-1:0]                  coreId,
    input  logic                                          popValid,
    input  logic [$clog2(NB_QUEUES)-1:0]                  popId,
    output logic [NB_QUEUES*PACKET_WIDTH-1:0]             headPacket,
    output logic [NB_QUEUES-1:0]                          queueEmpty,
    output logic [NB_QUEUES-1:0]                          queueFull,
    output logic [NB_QUEUES*$clog2(QUEUE_DEPTH+1)-1:0]    queueCount,
    output logic [15:0]                                   dropCount
);
    localparam int IW = $clog2(NB_QUEUES);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH+1);

    for (genvar q = 0; q < NB_QUEUES; q++) begin : g_queue
        logic [PACKET_WIDTH-1:0] mem [QUEUE_DEPTH];
        logic [PW-1:0]           wr_ptr;
        logic [PW-1:0]           rd_ptr;
        logic [CW-1:0]           cnt;
        logic                    push_req;
        logic                    pop_req;
        logic                    is_empty;
        logic                    is_full;
        logic                    push_ok;
        logic                    pop_ok;

        assign push_req = packetValid && (coreId == IW'(q));
        assign pop_req  = popValid && (popId == IW'(q));
        assign is_empty = (cnt == '0);
        assign is_full  = (cnt == CW'(QUEUE_DEPTH));
        assign pop_ok   = pop_req && !is_empty;
        // A same-cycle pop frees the slot a full queue needs for the incoming push.
        assign push_ok  = push_req && (!is_full || pop_ok);

        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
                if (push_ok && !pop_ok)
                    cnt <= cnt + 1'b1;
                else if (pop_ok && !push_ok)
                    cnt <= cnt - 1'b1;
            end
        end

        always_ff @(posedge S_AXI_ACLK) begin
            if (push_ok) mem[wr_ptr] <= packetIn;
        end

        assign headPacket[q*PACKET_WIDTH +: PACKET_WIDTH] = mem[rd_ptr];
        assign queueCount[q*CW +: CW]                      = cnt;
        assign queueEmpty[q]                               = is_empty;
        assign queueFull[q]                                = is_full;
    end

`ifdef CORE_QUEUE_BANK_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_cnt;

    assign drop = packetValid && queueFull[coreId] && !(popValid && (popId == coreId));

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
            drop_cnt <= 16'h0;
        else if (drop && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
    end

    assign dropCount = drop_cnt;
`else
    assign dropCount = 16'h0;
`endif

endmodule

// File: tb/tb_core_queue_bank.sv
// Directed bench for core_queue_bank with a queue-level reference model checked every cycle.
module tb_core_queue_bank;
    localparam int PWID = 294;
    localparam int NQ   = 4;
    localparam int DEP  = 8;
    localparam int CW   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PWID-1:0]   packetIn = '0;
    logic              packetValid = 1'b0;
    logic [1:0]        coreId = '0;
    logic              popValid = 1'b0;
    logic [1:0]        popId = '0;
    logic [NQ*PWID-1:0] headPacket;
    logic [NQ-1:0]     queueEmpty;
    logic [NQ-1:0]     queueFull;
    logic [NQ*CW-1:0]  queueCount;
    logic [15:0]       dropCount;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    logic [PWID-1:0] mq [NQ][$];
    logic [15:0]     mdrop = 16'h0;

    core_queue_bank #(.PACKET_WIDTH(PWID), .NB_QUEUES(NQ), .QUEUE_DEPTH(DEP)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .packetIn(packetIn), .packetValid(packetValid), .coreId(coreId),
        .popValid(popValid), .popId(popId),
        .headPacket(headPacket), .queueEmpty(queueEmpty), .queueFull(queueFull),
        .queueCount(queueCount), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    function automatic logic [PWID-1:0] mkpkt(input logic [7:0] b);
        logic [295:0] t;
        t = {37{b}};
        return t[PWID-1:0];
    endfunction

    function automatic logic [PWID-1:0] head_of(input int q);
        return headPacket[q*PWID +: PWID];
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int q);
        return queueCount[q*CW +: CW];
    endfunction

    function automatic logic [15:0] exp_drop();
`ifdef CORE_QUEUE_BANK_DROP_CNT_EN
        return mdrop;
`else
        return 16'h0;
`endif
    endfunction

    task automatic chk(input string name, input logic [PWID-1:0] act, input logic [PWID-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_upd(input bit pv, input int cid, input logic [PWID-1:0] pkt,
                             input bit ppv, input int pid);
        bit pop_ok;
        bit push_ok;
        pop_ok  = ppv && (mq[pid].size() > 0);
        push_ok = pv && ((mq[cid].size() < DEP) || (pop_ok && pid == cid));
        if (pop_ok) void'(mq[pid].pop_front());
        if (push_ok) mq[cid].push_back(pkt);
        else if (pv && mdrop != 16'hFFFF) mdrop++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NQ; i++) mq[i].delete();
        mdrop = 16'h0;
    endtask

    task automatic step(input bit pv, input int cid, input logic [PWID-1:0] pkt,
                        input bit ppv, input int pid);
        @(negedge clk);
        packetValid = pv;
        coreId      = cid[1:0];
        packetIn    = pkt;
        popValid    = ppv;
        popId       = pid[1:0];
        @(posedge clk);
        model_upd(pv, cid, pkt, ppv, pid);
        #1;
        packetValid = 1'b0;
        popValid    = 1'b0;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            for (int q = 0; q < NQ; q++) begin
                chk("empty", PWID'(queueEmpty[q]), PWID'(mq[q].size() == 0));
                chk("full",  PWID'(queueFull[q]),  PWID'(mq[q].size() == DEP));
                chk("count", PWID'(cnt_of(q)),     PWID'(mq[q].size()));
                if (mq[q].size() > 0) chk("head", head_of(q), mq[q][0]);
            end
            chk("drop", PWID'(dropCount), PWID'(exp_drop()));
        end
    end

    initial begin
        #12;
        chk("rst_empty", PWID'(queueEmpty), PWID'(4'hF));
        chk("rst_full",  PWID'(queueFull),  PWID'(4'h0));
        chk("rst_count", PWID'(queueCount), PWID'(16'h0));
        chk("rst_drop",  PWID'(dropCount),  PWID'(16'h0));
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Single push to queue 2
        step(1, 2, mkpkt(8'hA5), 0, 0);
        chk("p2_empty", PWID'(queueEmpty), PWID'(4'b1011));
        chk("p2_count", PWID'(cnt_of(2)), PWID'(1));
        chk("p2_head",  head_of(2), mkpkt(8'hA5));
        step(0, 0, '0, 1, 2);
        chk("p2_drain", PWID'(cnt_of(2)), PWID'(0));

        // Fill queue 1 and overflow it once
        for (int i = 0; i < 9; i++) step(1, 1, mkpkt(8'h10 + 8'(i)), 0, 0);
        chk("q1_full",  PWID'(queueFull[1]), PWID'(1));
        chk("q1_count", PWID'(cnt_of(1)), PWID'(8));
        chk("q1_head",  head_of(1), mkpkt(8'h10));
`ifdef CORE_QUEUE_BANK_DROP_CNT_EN
        chk("q1_drop",  PWID'(dropCount), PWID'(16'd1));
`else
        chk("q1_drop",  PWID'(dropCount), PWID'(16'd0));
`endif

        // Push+pop on a full queue
        step(1, 1, mkpkt(8'h19), 1, 1);
        chk("fpp_count", PWID'(cnt_of(1)), PWID'(8));
        chk("fpp_head",  head_of(1), mkpkt(8'h11));
        chk("fpp_drop",  PWID'(dropCount), PWID'(exp_drop()));

        // Pop of empty queue 0 alongside a push to queue 3
        step(1, 3, mkpkt(8'h30), 1, 0);
        chk("e0_empty", PWID'(queueEmpty[0]), PWID'(1));
        chk("e0_count", PWID'(cnt_of(0)), PWID'(0));
        chk("q3_count", PWID'(cnt_of(3)), PWID'(1));
        chk("q3_head",  head_of(3), mkpkt(8'h30));

        // 20 pushes with a pop every cycle on queue 0: pointers wrap twice
        for (int i = 0; i < 20; i++) begin
            if (i > 0) chk("wrap_head", head_of(0), mkpkt(8'h40 + 8'(i - 1)));
            step(1, 0, mkpkt(8'h40 + 8'(i)), 1, 0);
            chk("wrap_count", PWID'(cnt_of(0)), PWID'(1));
        end
        chk("wrap_last", head_of(0), mkpkt(8'h53));
        step(0, 0, '0, 1, 0);
        chk("wrap_final", PWID'(cnt_of(0)), PWID'(0));

`ifdef CORE_QUEUE_BANK_DROP_CNT_EN
        // Saturate the drop counter against full queue 1
        for (int i = 0; i < 65540; i++) step(1, 1, mkpkt(8'hEE), 0, 0);
        chk("drop_sat", PWID'(dropCount), PWID'(16'hFFFF));
        step(1, 1, mkpkt(8'hEF), 0, 0);
        chk("drop_hold", PWID'(dropCount), PWID'(16'hFFFF));
`else
        for (int i = 0; i < 5; i++) step(1, 1, mkpkt(8'hEE), 0, 0);
        chk("drop_tied", PWID'(dropCount), PWID'(16'h0));
`endif
        chk("q1_kept", head_of(1), mkpkt(8'h11));

        // Mid-burst asynchronous reset
        for (int i = 0; i < 6; i++) step(1, i % NQ, mkpkt(8'h60 + 8'(i)), 0, 0);
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        cmp_en = 1'b0;
        #1;
        chk("arst_empty", PWID'(queueEmpty), PWID'(4'hF));
        chk("arst_full",  PWID'(queueFull),  PWID'(4'h0));
        chk("arst_count", PWID'(queueCount), PWID'(16'h0));
        chk("arst_drop",  PWID'(dropCount),  PWID'(16'h0));
        model_clear();
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        step(1, 0, mkpkt(8'h77), 0, 0);
        chk("post_count", PWID'(cnt_of(0)), PWID'(1));
        chk("post_head",  head_of(0), mkpkt(8'h77));
        chk("post_empty", PWID'(queueEmpty), PWID'(4'b1110));
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
